// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: removes stuff bits after RUN_LEN equal bits,
// forwards payload bits as one-cycle strobes, and flags stuff errors.
module can_bit_destuff #(
    parameter int unsigned RUN_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       rx_bit,
    input  logic       stuff_en,
    input  logic       clear,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic [2:0] run_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        EXPECT_STUFF,
        ERROR
    } state_t;

    localparam logic [2:0] RUN_MAX = 3'(RUN_LEN);

    state_t     state, state_n;
    logic       last_bit, last_bit_n;
    logic [2:0] run_cnt_n;
    logic [2:0] run_inc;
    logic       bit_out_n, bit_valid_n, stuff_bit_n, stuff_err_n;

    // Saturating increment of the current run length.
    always_comb begin
        run_inc = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 3'd1;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_n     = state;
        last_bit_n  = last_bit;
        run_cnt_n   = run_cnt;
        bit_out_n   = bit_out;
        bit_valid_n = 1'b0;
        stuff_bit_n = 1'b0;
        stuff_err_n = stuff_err;

        if (clear) begin
            // Clear wins over a coincident sample; the sample is dropped.
            state_n     = IDLE;
            last_bit_n  = 1'b1;
            run_cnt_n   = '0;
            bit_out_n   = 1'b0;
            stuff_err_n = 1'b0;
        end else if (state == ERROR) begin
            stuff_err_n = 1'b1;
        end else if (!stuff_en) begin
            // Outside the stuffed region every sample is a plain pass-through.
            state_n    = IDLE;
            last_bit_n = 1'b1;
            run_cnt_n  = '0;
            if (sample_en) begin
                bit_out_n   = rx_bit;
                bit_valid_n = 1'b1;
            end
        end else if (sample_en) begin
            case (state)
                IDLE: begin
                    state_n     = ACTIVE;
                    run_cnt_n   = 3'd1;
                    last_bit_n  = rx_bit;
                    bit_out_n   = rx_bit;
                    bit_valid_n = 1'b1;
                end
                ACTIVE: begin
                    run_cnt_n   = (rx_bit == last_bit) ? run_inc : 3'd1;
                    last_bit_n  = rx_bit;
                    bit_out_n   = rx_bit;
                    bit_valid_n = 1'b1;
                    if (run_cnt_n == RUN_MAX) begin
                        state_n = EXPECT_STUFF;
                    end
                end
                EXPECT_STUFF: begin
                    if (rx_bit != last_bit) begin
                        state_n     = ACTIVE;
                        stuff_bit_n = 1'b1;
                        run_cnt_n   = 3'd1;
                        last_bit_n  = rx_bit;
                    end else begin
                        state_n     = ERROR;
                        stuff_err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_bit  <= 1'b1;
            run_cnt   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            stuff_bit <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            state     <= state_n;
            last_bit  <= last_bit_n;
            run_cnt   <= run_cnt_n;
            bit_out   <= bit_out_n;
            bit_valid <= bit_valid_n;
            stuff_bit <= stuff_bit_n;
            stuff_err <= stuff_err_n;
        end
    end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Scoreboard bench for can_bit_destuff: driver pushes expected strobes from a
// history-based reference model, monitor pops and compares on each strobe.
module tb_can_bit_destuff;

    localparam int RUN_LEN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic       rx_bit = 1'b0;
    logic       stuff_en = 1'b0;
    logic       clear = 1'b0;
    logic       bit_out, bit_valid, stuff_bit, stuff_err;
    logic [2:0] run_cnt;

    can_bit_destuff #(.RUN_LEN(RUN_LEN)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .rx_bit(rx_bit),
        .stuff_en(stuff_en), .clear(clear), .bit_out(bit_out),
        .bit_valid(bit_valid), .stuff_bit(stuff_bit), .stuff_err(stuff_err),
        .run_cnt(run_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_stuff;
        logic       b;
        logic [2:0] rc;
    } exp_t;

    exp_t exp_q[$];
    logic hist[$];
    logic model_err = 1'b0;
    logic err_exp;
    int   total = 0;
    int   bad = 0;
    int   valid_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Number of equal bits at the end of the in-region history.
    function automatic int trailing();
        int k = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) k++;
            else break;
        end
        return k;
    endfunction

    function automatic logic [2:0] sat_run();
        int k = trailing();
        return 3'((k > RUN_LEN) ? RUN_LEN : k);
    endfunction

    // Apply one cycle of inputs and update the reference model.
    task automatic drive(input logic s_en, input logic b, input logic st, input logic cl);
        exp_t e;
        @(posedge clk);
        #1;
        sample_en = s_en; rx_bit = b; stuff_en = st; clear = cl;
        if (cl) begin
            hist.delete();
            model_err = 1'b0;
        end else if (model_err) begin
            // stuck until clear
        end else if (!st) begin
            hist.delete();
            if (s_en) begin
                e.is_stuff = 1'b0; e.b = b; e.rc = 3'd0;
                exp_q.push_back(e);
            end
        end else if (s_en) begin
            if (hist.size() > 0 && trailing() >= RUN_LEN) begin
                if (b != hist[hist.size()-1]) begin
                    hist.push_back(b);
                    e.is_stuff = 1'b1; e.b = b; e.rc = sat_run();
                    exp_q.push_back(e);
                end else begin
                    model_err = 1'b1;
                end
            end else begin
                hist.push_back(b);
                e.is_stuff = 1'b0; e.b = b; e.rc = sat_run();
                exp_q.push_back(e);
            end
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic seq(input logic st, input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) drive(1'b1, bits[i], st, 1'b0);
    endtask

    task automatic idle(input logic st, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, st, 1'b0);
    endtask

    // Error flag follows the model one registered cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) err_exp <= 1'b0;
        else     err_exp <= model_err;
    end

    // Monitor: pop one expectation per strobe and check the sticky flag.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bit_valid && stuff_bit) check("both_strobes", 1, 0);
            if (bit_valid || stuff_bit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", int'(stuff_bit), int'(e.is_stuff));
                    check("run_cnt", int'(run_cnt), int'(e.rc));
                    if (!e.is_stuff) begin
                        check("bit_out", int'(bit_out), int'(e.b));
                        valid_seen++;
                    end
                end
            end
            check("stuff_err", int'(stuff_err), int'(err_exp));
        end
    end

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst = 1'b1;
        hist.delete();
        exp_q.delete();
        model_err = 1'b0;
        #1;
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_stuff_bit", int'(stuff_bit), 0);
        check("rst_stuff_err", int'(stuff_err), 0);
        check("rst_run_cnt", int'(run_cnt), 0);
        #5;
        rst = 1'b0;
    endtask

    initial begin
        int v0;
        logic prev_b;
        reset_pulse();
        idle(1'b0, 2);

        // Stuff removal: 0,0,0,0,0,1(stuff),0,1
        seq(1'b1, 8, 16'b1010_0000);
        idle(1'b0, 3);

        // Stuff error on six 1s, further samples ignored, then clear.
        seq(1'b1, 8, 16'b1111_1111);
        idle(1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 3);

        // Stuff bit starts a new run: 0x5, 1(stuff), 1x4, 0(stuff)
        seq(1'b1, 11, 16'b011_1110_0000);
        idle(1'b0, 3);

        // Pass-through outside the stuffed region.
        seq(1'b0, 8, 16'b1111_1111);
        idle(1'b0, 3);

        // clear coincident with sample_en drops the sample.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b0, 3);

        // Reset in the middle of a run.
        seq(1'b1, 4, 16'b0000);
        idle(1'b1, 1);
        @(negedge clk);
        check("run_cnt_held", int'(run_cnt), 4);
        idle(1'b1, 2);
        reset_pulse();
        seq(1'b1, 6, 16'b10_0000);
        idle(1'b0, 3);

        // Back-to-back: 0x5,1(stuff),1x4,0(stuff),1 -> 10 forwarded bits.
        v0 = valid_seen;
        seq(1'b1, 12, 16'b1011_1110_0000);
        idle(1'b0, 3);
        check("b2b_valid_count", valid_seen - v0, 10);

        // Randomized traffic with long runs, gaps, region toggles and clears.
        prev_b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic s, b, st, cl;
            s  = ($urandom_range(0, 9) < 7);
            b  = ($urandom_range(0, 99) < 80) ? prev_b : ~prev_b;
            st = ($urandom_range(0, 99) < 92);
            cl = ($urandom_range(0, 99) < 2);
            if (s) prev_b = b;
            drive(s, b, st, cl);
        end
        idle(1'b0, 4);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
